// File: rtl/trace_capture_fifo.sv
// trace_capture_fifo
//   Commit-trace buffer between the CPU commit point and a logging/debug sink.
//   Each retired instruction presented on i_commitValid is stamped with a
//   free-running 32-bit cycle count and queued in a DEPTH-entry FIFO.
//   Records drain over a valid/ready port. The CPU is never back-pressured:
//   a record arriving while the FIFO is full (and nothing pops) is dropped.
//   Dropped records are counted in a saturating counter and latched in a
//   sticky overflow flag.
//
// Ports
//   i_clock, i_resetn      clock (rising edge), asynchronous active-low reset
//   i_clear                synchronous flush of FIFO and drop/overflow status
//   i_commitValid          commit record presented this cycle
//   i_PC, i_instr          committed PC / instruction word
//   i_rdAddr, i_result     destination register index / value written
//   o_trValid, i_trReady   head-record handshake towards the sink
//   o_trCycle .. o_trResult  head record (all zero while empty)
//   o_count                entries held, 0..DEPTH
//   o_dropCount            records dropped since reset/clear (saturating)
//   o_overflow             sticky: at least one record was dropped
module trace_capture_fifo #(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                       i_clock,
  input  logic                       i_resetn,
  input  logic                       i_clear,
  input  logic                       i_commitValid,
  input  logic [31:0]                i_PC,
  input  logic [31:0]                i_instr,
  input  logic [4:0]                 i_rdAddr,
  input  logic [31:0]                i_result,
  output logic                       o_trValid,
  input  logic                       i_trReady,
  output logic [31:0]                o_trCycle,
  output logic [31:0]                o_trPC,
  output logic [31:0]                o_trInstr,
  output logic [4:0]                 o_trRdAddr,
  output logic [31:0]                o_trResult,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [DROP_W-1:0]          o_dropCount,
  output logic                       o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == DROP_MAX) ? v : v + DROP_W'(1);
  endfunction

  // Record storage is data only: no reset, written only on an accepted push.
  logic [31:0] mem_cycle  [DEPTH];
  logic [31:0] mem_pc     [DEPTH];
  logic [31:0] mem_instr  [DEPTH];
  logic [4:0]  mem_rd     [DEPTH];
  logic [31:0] mem_result [DEPTH];

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [31:0]   cycle_q;
  logic [DROP_W-1:0] drop_q;
  logic          ovf_q;

  logic empty;
  logic full;
  logic pop_req;
  logic pop;
  logic push;
  logic drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees a slot in the same cycle, so a full FIFO can still accept
  // a push when the sink takes the head. Clear overrides both.
  assign pop_req = !empty && i_trReady;
  assign pop     = pop_req && !i_clear;
  assign push    = i_commitValid && (!full || pop_req) && !i_clear;
  assign drop    = i_commitValid && full && !pop_req && !i_clear;

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      cycle_q <= 32'd0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
    end
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else if (i_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (drop) begin
        drop_q <= sat_inc(drop_q);
        ovf_q  <= 1'b1;
      end
    end
  end

  // Stamp is the counter value of the push cycle (pre-increment).
  always_ff @(posedge i_clock) begin
    if (push) begin
      mem_cycle[wr_ptr[AW-1:0]]  <= cycle_q;
      mem_pc[wr_ptr[AW-1:0]]     <= i_PC;
      mem_instr[wr_ptr[AW-1:0]]  <= i_instr;
      mem_rd[wr_ptr[AW-1:0]]     <= i_rdAddr;
      mem_result[wr_ptr[AW-1:0]] <= i_result;
    end
  end

  // Head is read from registered pointers only, so a push becomes visible
  // one cycle later and never falls through combinationally.
  always_comb begin
    o_trValid  = !empty;
    o_trCycle  = 32'd0;
    o_trPC     = 32'd0;
    o_trInstr  = 32'd0;
    o_trRdAddr = 5'd0;
    o_trResult = 32'd0;
    if (!empty) begin
      o_trCycle  = mem_cycle[rd_ptr[AW-1:0]];
      o_trPC     = mem_pc[rd_ptr[AW-1:0]];
      o_trInstr  = mem_instr[rd_ptr[AW-1:0]];
      o_trRdAddr = mem_rd[rd_ptr[AW-1:0]];
      o_trResult = mem_result[rd_ptr[AW-1:0]];
    end
  end

  assign o_count     = wr_ptr - rd_ptr;
  assign o_dropCount = drop_q;
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_trace_capture_fifo.sv
module tb_trace_capture_fifo;
  localparam int DEPTH  = 16;
  localparam int DROP_W = 16;

  logic        i_clock = 1'b0;
  logic        i_resetn;
  logic        i_clear;
  logic        i_commitValid;
  logic [31:0] i_PC;
  logic [31:0] i_instr;
  logic [4:0]  i_rdAddr;
  logic [31:0] i_result;
  logic        o_trValid;
  logic        i_trReady;
  logic [31:0] o_trCycle;
  logic [31:0] o_trPC;
  logic [31:0] o_trInstr;
  logic [4:0]  o_trRdAddr;
  logic [31:0] o_trResult;
  logic [$clog2(DEPTH):0] o_count;
  logic [DROP_W-1:0] o_dropCount;
  logic        o_overflow;

  trace_capture_fifo #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .i_clock(i_clock), .i_resetn(i_resetn), .i_clear(i_clear),
    .i_commitValid(i_commitValid), .i_PC(i_PC), .i_instr(i_instr),
    .i_rdAddr(i_rdAddr), .i_result(i_result),
    .o_trValid(o_trValid), .i_trReady(i_trReady),
    .o_trCycle(o_trCycle), .o_trPC(o_trPC), .o_trInstr(o_trInstr),
    .o_trRdAddr(o_trRdAddr), .o_trResult(o_trResult),
    .o_count(o_count), .o_dropCount(o_dropCount), .o_overflow(o_overflow)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [31:0] cyc;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] res;
  } rec_t;

  rec_t        sb[$];
  int          m_drop;
  bit          m_ovf;
  logic [31:0] tb_cyc;
  int          checks;
  int          failures;
  int          seq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the scoreboard head / model status.
  task automatic check_outputs();
    rec_t h;
    h = '{cyc: 32'd0, pc: 32'd0, instr: 32'd0, rd: 5'd0, res: 32'd0};
    if (sb.size() != 0) h = sb[0];
    chk("valid",    {31'd0, o_trValid}, {31'd0, sb.size() != 0});
    chk("trCycle",  o_trCycle, h.cyc);
    chk("trPC",     o_trPC, h.pc);
    chk("trInstr",  o_trInstr, h.instr);
    chk("trRd",     {27'd0, o_trRdAddr}, {27'd0, h.rd});
    chk("trResult", o_trResult, h.res);
    chk("count",    32'(o_count), 32'(sb.size()));
    chk("dropCount", 32'(o_dropCount), 32'(m_drop));
    chk("overflow", {31'd0, o_overflow}, {31'd0, m_ovf});
  endtask

  // One clock cycle: check at negedge, drive, update model, advance.
  task automatic step(input bit cv, input bit rdy, input bit clr,
                      input logic [31:0] pc, input logic [31:0] instr,
                      input logic [4:0] rd, input logic [31:0] res);
    bit do_pop;
    bit do_push;
    rec_t r;
    check_outputs();
    i_commitValid = cv;
    i_trReady     = rdy;
    i_clear       = clr;
    i_PC          = pc;
    i_instr       = instr;
    i_rdAddr      = rd;
    i_result      = res;
    do_pop  = (sb.size() != 0) && rdy;
    do_push = cv && ((sb.size() < DEPTH) || do_pop);
    if (clr) begin
      sb.delete();
      m_drop = 0;
      m_ovf  = 1'b0;
    end else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) begin
        r = '{cyc: tb_cyc, pc: pc, instr: instr, rd: rd, res: res};
        sb.push_back(r);
      end else if (cv) begin
        if (m_drop < (1 << DROP_W) - 1) m_drop++;
        m_ovf = 1'b1;
      end
    end
    @(posedge i_clock);
    tb_cyc = tb_cyc + 32'd1;
    @(negedge i_clock);
  endtask

  task automatic rstep(input bit cv, input bit rdy, input bit clr);
    seq++;
    step(cv, rdy, clr, 32'h1000 + 32'(seq) * 4, $urandom, 5'(seq), $urandom);
  endtask

  task automatic release_reset();
    i_resetn = 1'b1;
    tb_cyc   = 32'd0;
    sb.delete();
    m_drop   = 0;
    m_ovf    = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; seq = 0;
    m_drop = 0; m_ovf = 1'b0; tb_cyc = 32'd0;
    i_resetn = 1'b0; i_clear = 1'b0; i_commitValid = 1'b0; i_trReady = 1'b0;
    i_PC = '0; i_instr = '0; i_rdAddr = '0; i_result = '0;
    @(negedge i_clock);
    @(negedge i_clock);
    chk("rst_valid", {31'd0, o_trValid}, 32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
    release_reset();

    // 1) first record: pushed in cycle 3, visible in cycle 4, gone in cycle 5
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 32'h0, 32'h00500093, 5'd1, 32'd5);
    chk("t1_valid", {31'd0, o_trValid}, 32'd1);
    chk("t1_cycle", o_trCycle, 32'd3);
    chk("t1_instr", o_trInstr, 32'h00500093);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("t1_empty", {31'd0, o_trValid}, 32'd0);

    // 2) fill to DEPTH, 17th push dropped
    for (int i = 0; i < DEPTH; i++) rstep(1, 0, 0);
    chk("t2_full", 32'(o_count), 32'(DEPTH));
    rstep(1, 0, 0);
    chk("t2_drop", 32'(o_dropCount), 32'd1);
    chk("t2_ovf", {31'd0, o_overflow}, 32'd1);

    // 3) full with simultaneous push and pop, then drain in order
    rstep(1, 1, 0);
    chk("t3_count", 32'(o_count), 32'(DEPTH));
    chk("t3_drop", 32'(o_dropCount), 32'd1);
    for (int i = 0; i < DEPTH; i++) rstep(0, 1, 0);
    chk("t3_empty", 32'(o_count), 32'd0);

    // 4) hold head under back-pressure, then mixed traffic across wraps
    rstep(1, 0, 0);
    for (int i = 0; i < 5; i++) rstep(0, 0, 0);
    for (int i = 0; i < 40; i++) rstep(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    for (int i = 0; i < DEPTH + 1; i++) rstep(0, 1, 0);
    chk("t4_empty", 32'(o_count), 32'd0);

    // 5) clear with a concurrent push while overflow is set
    for (int i = 0; i < 7; i++) rstep(1, 0, 0);
    chk("t5_count7", 32'(o_count), 32'd7);
    chk("t5_ovf_set", {31'd0, o_overflow}, 32'd1);
    rstep(1, 0, 1);
    chk("t5_count0", 32'(o_count), 32'd0);
    chk("t5_drop0", 32'(o_dropCount), 32'd0);
    chk("t5_ovf0", {31'd0, o_overflow}, 32'd0);
    chk("t5_valid0", {31'd0, o_trValid}, 32'd0);
    rstep(1, 0, 0);
    rstep(0, 1, 0);

    // 6) counter wrap stamps, then asynchronous reset mid-drain
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_q;
    tb_cyc = 32'hFFFF_FFFF;
    rstep(1, 0, 0);
    rstep(1, 0, 0);
    chk("t6_stamp_max", o_trCycle, 32'hFFFF_FFFF);
    rstep(0, 1, 0);
    chk("t6_stamp_wrap", o_trCycle, 32'd0);
    rstep(1, 0, 0);
    rstep(1, 1, 0);
    #2;
    i_resetn = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, o_trValid}, 32'd0);
    chk("t6_rst_count", 32'(o_count), 32'd0);
    chk("t6_rst_pc", o_trPC, 32'd0);
    i_commitValid = 1'b0;
    i_trReady = 1'b0;
    @(negedge i_clock);
    release_reset();
    rstep(0, 1, 0);
    rstep(1, 1, 0);
    rstep(0, 1, 0);
    rstep(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
